// File: rtl/d_mem_sized.sv
// d_mem_sized: byte-addressed data memory with req/ready handshake, wait states,
// byte/half/word accesses with load extension, and error reporting.
module d_mem_sized #(
  parameter int MemSize    = 10,
  parameter int WaitStates = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Valid,
  output logic        Error
);
  localparam int Words = 1 << MemSize;
  localparam logic [32:0] Bytes = 33'(Words) << 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] count;
  logic [31:0] addr_q, wdata_q;
  logic [1:0] size_q;
  logic uns_q, rd_q, wr_q;
  logic [31:0] mem [Words];
  logic idle, access, un, rd, wr, err;
  logic [31:0] a, wd, word, shifted, load, lanes;
  logic [1:0] sz;
  logic [3:0] be;
  logic [MemSize-1:0] idx;
  assign idle  = state == IDLE;
  assign Ready = idle;
  // With zero wait states the access happens on the accept edge itself, so the
  // operands come straight from the ports; otherwise from the latched copy.
  assign access = reset_n && (idle ? (Req && (WaitStates == 0)) : (state == WAIT && count == 4'd0));
  assign a  = idle ? Address   : addr_q;
  assign wd = idle ? WriteData : wdata_q;
  assign sz = idle ? Size      : size_q;
  assign un = idle ? Unsigned  : uns_q;
  assign rd = idle ? MemRead   : rd_q;
  assign wr = idle ? MemWrite  : wr_q;
  assign idx = a[MemSize+1:2];
  assign err = (rd && wr) || sz == 2'b11 || {1'b0, a} >= Bytes ||
               (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  assign word    = mem[idx];
  assign shifted = word >> {a[1:0], 3'b000};
  assign load = sz == 2'b00 ? {{24{!un && shifted[7]}}, shifted[7:0]} :
                sz == 2'b01 ? {{16{!un && shifted[15]}}, shifted[15:0]} : word;
  assign be = sz == 2'b00 ? 4'b0001 << a[1:0] : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lanes = sz == 2'b00 ? {4{wd[7:0]}} : sz == 2'b01 ? {2{wd[15:0]}} : wd;
  always_ff @(posedge clock)
    if (access && wr && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      ReadData <= '0;
      Valid    <= 1'b0;
      Error    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      Valid <= access;
      if (access) begin
        ReadData <= (err || !rd) ? '0 : load;
        Error    <= err;
      end
      case (state)
        IDLE: if (Req) begin
          addr_q  <= Address;
          wdata_q <= WriteData;
          size_q  <= Size;
          uns_q   <= Unsigned;
          rd_q    <= MemRead;
          wr_q    <= MemWrite;
          state   <= (WaitStates == 0) ? RESP : WAIT;
          count   <= 4'((WaitStates == 0) ? 0 : WaitStates - 1);
        end
        WAIT: begin
          state <= (count == 4'd0) ? RESP : WAIT;
          count <= (count == 4'd0) ? count : count - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_d_mem_sized.sv
// tb_d_mem_sized: randomized self-checking bench for d_mem_sized at 0 and 3
// wait states against a byte-array reference model.
module tb_d_mem_sized;
  logic clock = 0, reset_n = 1;
  logic req0 = 0, req3 = 0, mem_read = 0, mem_write = 0, uns = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata0, rdata3;
  logic ready0, ready3, valid0, valid3, error0, error3;
  int passed = 0, total = 0, cyc = 0;
  logic [7:0] mb [2][4096];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  d_mem_sized #(.MemSize(10), .WaitStates(0)) u0 (
    .clock(clock), .reset_n(reset_n), .Req(req0), .MemRead(mem_read), .MemWrite(mem_write),
    .Size(size), .Unsigned(uns), .Address(addr), .WriteData(wdata),
    .ReadData(rdata0), .Ready(ready0), .Valid(valid0), .Error(error0));

  d_mem_sized #(.MemSize(10), .WaitStates(3)) u3 (
    .clock(clock), .reset_n(reset_n), .Req(req3), .MemRead(mem_read), .MemWrite(mem_write),
    .Size(size), .Unsigned(uns), .Address(addr), .WriteData(wdata),
    .ReadData(rdata3), .Ready(ready3), .Valid(valid3), .Error(error3));

  task automatic preload(input int d, input int w, input logic [31:0] v);
    if (d == 0) u0.mem[w] = v; else u3.mem[w] = v;
    for (int i = 0; i < 4; i++) mb[d][4*w+i] = v[8*i +: 8];
  endtask

  // Byte-level view: an access touches 1<<size consecutive bytes, lowest address = least significant.
  function automatic void model(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                                input logic un, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] r, output logic e);
    int n = 1 << sz;
    e = (rd && wr) || sz == 2'b11 || a >= 32'd4096 || (a % n) != 0;
    r = 0;
    if (e) return;
    for (int i = 0; i < n; i++) begin
      if (wr) mb[d][a+i] = wd[8*i +: 8];
      if (rd) r[8*i +: 8] = mb[d][a+i];
    end
    if (rd && !un && n < 4 && r[8*n-1]) r = r | ~((32'd1 << (8*n)) - 32'd1);
  endfunction

  task automatic run(input int d, input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd, input string tag, output logic [31:0] r);
    logic [31:0] er;
    logic ee;
    int lat;
    model(d, rd, wr, sz, un, a, wd, er, ee);
    @(negedge clock);
    total++;
    if ((d ? ready3 : ready0) !== 1'b1) $display("FAIL %s ready_before: got %b want 1", tag, d ? ready3 : ready0);
    else passed++;
    mem_read = rd; mem_write = wr; size = sz; uns = un; addr = a; wdata = wd;
    if (d == 0) req0 = 1; else req3 = 1;
    @(posedge clock); #1;
    req0 = 0; req3 = 0;
    mem_read = $urandom; mem_write = $urandom; size = $urandom; uns = $urandom; addr = $urandom; wdata = $urandom;
    lat = 0;
    while ((d ? valid3 : valid0) !== 1'b1 && lat < 40) begin
      total++;
      if ((d ? ready3 : ready0) !== 1'b0) $display("FAIL %s ready_in_wait: got %b want 0", tag, d ? ready3 : ready0);
      else passed++;
      @(posedge clock); #1;
      lat++;
    end
    r = d ? rdata3 : rdata0;
    total++;
    if (lat != (d ? 3 : 0)) $display("FAIL %s latency: got %0d want %0d", tag, lat, d ? 3 : 0); else passed++;
    total++;
    if (r !== er) $display("FAIL %s rdata: got %h want %h", tag, r, er); else passed++;
    total++;
    if ((d ? error3 : error0) !== ee) $display("FAIL %s error: got %b want %b", tag, d ? error3 : error0, ee);
    else passed++;
    total++;
    if ((d ? ready3 : ready0) !== 1'b0) $display("FAIL %s ready_at_valid: got %b want 0", tag, d ? ready3 : ready0);
    else passed++;
    @(posedge clock); #1;
    total++;
    if ({d ? ready3 : ready0, d ? valid3 : valid0} !== 2'b10)
      $display("FAIL %s after_valid ready/valid: got %b want 10", tag, {d ? ready3 : ready0, d ? valid3 : valid0});
    else passed++;
    mem_read = 0; mem_write = 0;
  endtask

  task automatic test_reset();
    #1 reset_n = 0;
    #2;
    total++;
    if ({ready0, valid0, error0, rdata0, ready3, valid3, error3, rdata3} !== {3'b100, 32'd0, 3'b100, 32'd0})
      $display("FAIL reset_held: got %b%b%b %h %b%b%b %h want 100 0 100 0",
               ready0, valid0, error0, rdata0, ready3, valid3, error3, rdata3);
    else passed++;
    repeat (3) @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;
    total++;
    if ({ready0, valid0, error0, rdata0, ready3, valid3, error3, rdata3} !== {3'b100, 32'd0, 3'b100, 32'd0})
      $display("FAIL reset_release: got %b%b%b %h %b%b%b %h want 100 0 100 0",
               ready0, valid0, error0, rdata0, ready3, valid3, error3, rdata3);
    else passed++;
  endtask

  task automatic test_word();
    logic [31:0] r;
    run(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, "sw_word", r);
    run(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, "lw_word", r);
    total++;
    if (r !== 32'hDEADBEEF) $display("FAIL lw_word_const: got %h want deadbeef", r); else passed++;
  endtask

  task automatic test_lanes();
    logic [31:0] r;
    preload(0, 4, 32'h11223344);
    run(0, 0, 1, 2'b00, 0, 32'h11, 32'h55AA55AA, "sb", r);
    run(0, 1, 0, 2'b10, 0, 32'h10, 0, "lw_after_sb", r);
    total++;
    if (r !== 32'h1122AA44) $display("FAIL sb_word: got %h want 1122aa44", r); else passed++;
    run(0, 1, 0, 2'b00, 0, 32'h11, 0, "lb", r);
    total++;
    if (r !== 32'hFFFFFFAA) $display("FAIL lb_const: got %h want ffffffaa", r); else passed++;
    run(0, 1, 0, 2'b00, 1, 32'h11, 0, "lbu", r);
    total++;
    if (r !== 32'h000000AA) $display("FAIL lbu_const: got %h want 000000aa", r); else passed++;
    run(0, 0, 1, 2'b01, 0, 32'h12, 32'h12348001, "sh", r);
    run(0, 1, 0, 2'b01, 0, 32'h12, 0, "lh", r);
    total++;
    if (r !== 32'hFFFF8001) $display("FAIL lh_const: got %h want ffff8001", r); else passed++;
    run(0, 1, 0, 2'b01, 1, 32'h12, 0, "lhu", r);
    total++;
    if (r !== 32'h00008001) $display("FAIL lhu_const: got %h want 00008001", r); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] r;
    run(0, 1, 0, 2'b10, 0, 32'h13, 0, "err_lw_misalign", r);
    run(0, 1, 0, 2'b01, 0, 32'h11, 0, "err_lh_misalign", r);
    run(0, 0, 1, 2'b01, 0, 32'h11, 32'hFFFF, "err_sh_misalign", r);
    run(0, 0, 1, 2'b10, 0, 32'd4096, 32'h1, "err_range", r);
    run(0, 1, 1, 2'b10, 0, 32'h10, 32'h0, "err_rd_wr", r);
    run(0, 0, 1, 2'b11, 0, 32'h10, 32'h0, "err_size3", r);
    run(0, 1, 0, 2'b10, 0, 32'h10, 0, "after_errors", r);
    total++;
    if (r !== 32'h8001AA44) $display("FAIL errors_no_write: got %h want 8001aa44", r); else passed++;
    run(0, 0, 1, 2'b10, 0, 32'd4092, 32'hA5A5_0F0F, "sw_top", r);
    run(0, 1, 0, 2'b10, 0, 32'd4092, 0, "lw_top", r);
  endtask

  task automatic test_ignore();
    logic [31:0] er, r;
    logic ee;
    preload(1, 4, 32'hCAFEF00D);
    preload(1, 17, 32'h0BADC0DE);
    model(1, 1, 0, 2'b10, 0, 32'h10, 0, er, ee);
    @(negedge clock);
    mem_read = 1; mem_write = 0; size = 2'b10; uns = 0; addr = 32'h10; wdata = 0; req3 = 1;
    @(posedge clock); #1;
    mem_read = 0; mem_write = 1; addr = 32'h44; wdata = 32'hFFFFFFFF;
    repeat (2) begin @(posedge clock); #1; end
    req3 = 0;
    total++;
    if ({ready3, valid3} !== 2'b00) $display("FAIL ignore_wait: got %b want 00", {ready3, valid3}); else passed++;
    @(posedge clock); #1;
    total++;
    if ({valid3, error3, rdata3} !== {2'b10, er})
      $display("FAIL ignore_resp: got %b%b %h want 10 %h", valid3, error3, rdata3, er);
    else passed++;
    mem_write = 0;
    @(posedge clock); #1;
    run(1, 1, 0, 2'b10, 0, 32'h44, 0, "ignored_store", r);
    total++;
    if (r !== 32'h0BADC0DE) $display("FAIL ignored_store_const: got %h want 0badc0de", r); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic ee;
    int t[$];
    model(1, 1, 0, 2'b10, 0, 32'h10, 0, er, ee);
    @(negedge clock);
    mem_read = 1; mem_write = 0; size = 2'b10; uns = 0; addr = 32'h10; req3 = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (valid3) begin
        t.push_back(cyc);
        total++;
        if (rdata3 !== er) $display("FAIL b2b_rdata: got %h want %h", rdata3, er); else passed++;
      end
    end
    req3 = 0; mem_read = 0;
    total++;
    if (t.size() != 4) $display("FAIL b2b_count: got %0d want 4", t.size()); else passed++;
    for (int i = 1; i < t.size(); i++) begin
      total++;
      if (t[i] - t[i-1] != 5) $display("FAIL b2b_spacing: got %0d want 5", t[i] - t[i-1]); else passed++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic seen;
    preload(1, 8, 32'h0);
    @(negedge clock);
    mem_read = 0; mem_write = 1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678; req3 = 1;
    @(posedge clock); #1;
    req3 = 0;
    @(posedge clock); #1;
    reset_n = 0;
    #2;
    total++;
    if ({ready3, valid3} !== 2'b10) $display("FAIL reset_mid_held: got %b want 10", {ready3, valid3}); else passed++;
    @(negedge clock);
    reset_n = 1;
    mem_write = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      seen |= valid3;
    end
    total++;
    if (seen !== 1'b0 || ready3 !== 1'b1) $display("FAIL reset_mid_valid: got valid_seen=%b ready=%b want 0 1", seen, ready3);
    else passed++;
    run(1, 1, 0, 2'b10, 0, 32'h20, 0, "lw_after_reset", r);
    total++;
    if (r !== 32'h0) $display("FAIL reset_mid_discard: got %h want 00000000", r); else passed++;
  endtask

  task automatic test_noop();
    logic [31:0] r;
    for (int d = 0; d < 2; d++) begin
      run(d, 0, 0, 2'b10, 0, 32'h10, 32'hFFFFFFFF, "noop", r);
      total++;
      if (r !== 32'h0) $display("FAIL noop_rdata: got %h want 00000000", r); else passed++;
      run(d, 1, 0, 2'b10, 0, 32'h10, 0, "after_noop", r);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 40; i++) begin
        a = ($urandom_range(0, 15) == 0) ? 32'd4096 + $urandom_range(0, 1000) : $urandom_range(0, 255);
        run(d, $urandom, $urandom, $urandom, $urandom, a, $urandom, "random", r);
      end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) preload(d, w, $urandom);
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_noop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
